// File: rtl/ahb5_sram_responder_pkg.sv
// Shared AHB5 encodings, responder FSM state codes and byte-lane helpers.
package ahb5_sram_responder_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } resp_e;

    typedef logic [2:0] resp_state_e;
    localparam resp_state_e ST_IDLE = 3'd0;
    localparam resp_state_e ST_WAIT = 3'd1;
    localparam resp_state_e ST_DATA = 3'd2;
    localparam resp_state_e ST_ERR1 = 3'd3;
    localparam resp_state_e ST_ERR2 = 3'd4;

    function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr;
            HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ahb5_sram_responder_lfsr.sv
// Free-running 32-bit Galois LFSR (x^32+x^22+x^2+x+1), reseeded on reset.
module ahb5_sram_responder_lfsr #(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rstn,
    output logic [31:0] random_val
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            random_val <= SEED;
        end else begin
            random_val <= {1'b0, random_val[31:1]} ^ (random_val[0] ? 32'h8020_0003 : 32'h0);
        end
    end

endmodule

// File: rtl/ahb5_sram_responder.sv
// AHB5 word-memory subordinate with random wait states and two-cycle ERROR responses.
// State | meaning: IDLE no data phase | WAIT stalling | DATA final OKAY cycle | ERR1/ERR2 error response.
module ahb5_sram_responder
    import ahb5_sram_responder_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int MAX_WAIT  = 3,
    parameter bit WAIT_EN   = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    output logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic [15:0] TXN_COUNT,
    output logic [15:0] ERR_COUNT
);

    localparam int         AW       = $clog2(MEM_DEPTH);
    localparam logic [4:0] WAIT_MOD = 5'(MAX_WAIT + 1);

    logic [31:0]   mem [MEM_DEPTH];
    resp_state_e   state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [AW-1:0] a_idx;
    logic [1:0]    a_ofs;
    logic [2:0]    a_size;
    logic          a_write;
    logic [31:0]   lfsr;
    logic          accept, acc_err, mem_we;
    logic [AW-1:0] acc_idx;
    logic [3:0]    nw;
    logic [31:0]   wr_word, fwd_rd, rdata_n;
    logic          ready_n, resp_n;
    logic          unused_ok;

    ahb5_sram_responder_lfsr u_lfsr (
        .clk        (HCLK),
        .rstn       (HRESETn),
        .random_val (lfsr)
    );

    assign unused_ok = ^{HBURST, HPROT, lfsr[31:4]};

    assign accept  = HSEL & HREADY & ((HTRANS == TRANS_NONSEQ) | (HTRANS == TRANS_SEQ));
    assign acc_idx = HADDR[AW+1:2];
    assign acc_err = (HSIZE > HSIZE_WORD)
                   | ((HSIZE == HSIZE_HALF) & HADDR[0])
                   | ((HSIZE == HSIZE_WORD) & (|HADDR[1:0]))
                   | (HADDR[31:2] >= 30'(MEM_DEPTH));
    assign nw      = WAIT_EN ? 4'({1'b0, lfsr[3:0]} % WAIT_MOD) : 4'd0;

    // The write in DATA commits on the same edge a pipelined read is accepted, so forward it.
    assign mem_we  = (state == ST_DATA) & a_write;
    assign wr_word = merge_lanes(mem[a_idx], HWDATA, byte_lanes(a_size, a_ofs));
    assign fwd_rd  = (mem_we && (a_idx == acc_idx)) ? wr_word : mem[acc_idx];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ready_n = 1'b1;
        resp_n  = RESP_OKAY;
        rdata_n = '0;
        case (state)
            ST_WAIT: begin
                if (cnt == 4'd1) begin
                    state_n = ST_DATA;
                    if (!a_write) rdata_n = mem[a_idx];
                end else begin
                    cnt_n   = cnt - 4'd1;
                    ready_n = 1'b0;
                end
            end
            ST_ERR1: begin
                state_n = ST_ERR2;
                resp_n  = RESP_ERROR;
            end
            default: begin
                state_n = ST_IDLE;
                if (accept) begin
                    if (acc_err) begin
                        state_n = ST_ERR1;
                        ready_n = 1'b0;
                        resp_n  = RESP_ERROR;
                    end else if (nw != 4'd0) begin
                        state_n = ST_WAIT;
                        cnt_n   = nw;
                        ready_n = 1'b0;
                    end else begin
                        state_n = ST_DATA;
                        if (!HWRITE) rdata_n = fwd_rd;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            HREADY    <= 1'b1;
            HRESP     <= RESP_OKAY;
            HRDATA    <= '0;
            TXN_COUNT <= '0;
            ERR_COUNT <= '0;
            a_idx     <= '0;
            a_ofs     <= '0;
            a_size    <= '0;
            a_write   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            HREADY <= ready_n;
            HRESP  <= resp_n;
            HRDATA <= rdata_n;
            if (accept) begin
                a_idx   <= acc_idx;
                a_ofs   <= HADDR[1:0];
                a_size  <= HSIZE;
                a_write <= HWRITE;
            end
            if (state == ST_DATA) TXN_COUNT <= TXN_COUNT + 16'd1;
            if (state == ST_ERR2) ERR_COUNT <= ERR_COUNT + 16'd1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (mem_we) mem[a_idx] <= wr_word;
    end

endmodule

// File: tb/tb_ahb5_sram_responder.sv
// Bench: zero-wait instance for directed vectors, wait-state instance for random traffic and reset abort.
module tb_ahb5_sram_responder;
    import ahb5_sram_responder_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL0, HSEL1;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic        rdy0, resp0, rdy1, resp1;
    logic [31:0] rdata0, rdata1;
    logic [15:0] txn0, err0, txn1, err1;

    always #5 HCLK = ~HCLK;

    ahb5_sram_responder #(.MEM_DEPTH(256), .MAX_WAIT(3), .WAIT_EN(1'b0)) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL0), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HREADY(rdy0), .HRDATA(rdata0), .HRESP(resp0), .TXN_COUNT(txn0), .ERR_COUNT(err0));

    ahb5_sram_responder #(.MEM_DEPTH(256), .MAX_WAIT(3), .WAIT_EN(1'b1)) u_dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL1), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HREADY(rdy1), .HRDATA(rdata1), .HRESP(resp1), .TXN_COUNT(txn1), .ERR_COUNT(err1));

    typedef struct {
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        vec_t v;
        v.wr = wr; v.sz = sz; v.addr = addr; v.wd = wd; v.exp_rd = exp_rd; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Single non-pipelined transfer; called and returns on a falling edge with HREADY high.
    task automatic xfer(input bit sel, input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic rsp,
                        output int lows, output logic low_rsp);
        HSEL0 = !sel; HSEL1 = sel;
        HADDR = addr; HTRANS = TRANS_NONSEQ; HWRITE = wr; HSIZE = sz;
        @(negedge HCLK);
        HSEL0 = 1'b0; HSEL1 = 1'b0; HTRANS = TRANS_IDLE; HWDATA = wd;
        lows = 0; low_rsp = 1'b0;
        while ((sel ? rdy1 : rdy0) == 1'b0 && lows < 40) begin
            low_rsp = low_rsp | (sel ? resp1 : resp0);
            lows++;
            @(negedge HCLK);
        end
        rd  = sel ? rdata1 : rdata0;
        rsp = sel ? resp1 : resp0;
        @(negedge HCLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        rsp, low_rsp;
        int          lows, exp_txn, exp_err, low_total, t4_reads;
        logic [31:0] model [16];
        bit          got_wait;

        HRESETn = 1'b0; HSEL0 = 1'b0; HSEL1 = 1'b0; HADDR = '0; HTRANS = TRANS_IDLE;
        HWRITE = 1'b0; HSIZE = '0; HBURST = 3'b001; HPROT = 4'b0011; HWDATA = '0;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("reset hready", 32'(rdy0), 32'd1);
        chk("reset hresp", 32'(resp0), 32'd0);
        chk("reset hrdata", rdata0, 32'd0);
        chk("reset counts", {txn0, err0}, 32'd0);
        chk("reset counts inst1", {txn1, err1}, 32'd0);

        vecs.push_back(mk(1, HSIZE_WORD, 32'h10,  32'hDEADBEEF, 32'h0,        0));
        vecs.push_back(mk(0, HSIZE_WORD, 32'h10,  32'h0,        32'hDEADBEEF, 0));
        vecs.push_back(mk(1, HSIZE_WORD, 32'h10,  32'h11223344, 32'h0,        0));
        vecs.push_back(mk(1, HSIZE_BYTE, 32'h13,  32'hAA000000, 32'h0,        0));
        vecs.push_back(mk(0, HSIZE_WORD, 32'h10,  32'h0,        32'hAA223344, 0));
        vecs.push_back(mk(0, HSIZE_BYTE, 32'h11,  32'h0,        32'hAA223344, 0));
        vecs.push_back(mk(1, HSIZE_WORD, 32'h14,  32'h01020304, 32'h0,        0));
        vecs.push_back(mk(1, HSIZE_HALF, 32'h16,  32'hBBBB0000, 32'h0,        0));
        vecs.push_back(mk(1, HSIZE_HALF, 32'h14,  32'h12345678, 32'h0,        0));
        vecs.push_back(mk(1, HSIZE_BYTE, 32'h15,  32'h0000CD00, 32'h0,        0));
        vecs.push_back(mk(0, HSIZE_WORD, 32'h14,  32'h0,        32'hBBBBCD78, 0));
        vecs.push_back(mk(1, HSIZE_WORD, 32'h0,   32'hCAFEF00D, 32'h0,        0));
        vecs.push_back(mk(1, HSIZE_WORD, 32'h3FC, 32'h0F0F0F0F, 32'h0,        0));
        vecs.push_back(mk(0, HSIZE_WORD, 32'h3FC, 32'h0,        32'h0F0F0F0F, 0));
        vecs.push_back(mk(1, 3'd3,       32'h0,   32'hFFFFFFFF, 32'h0,        1));
        vecs.push_back(mk(1, HSIZE_HALF, 32'h1,   32'hFFFFFFFF, 32'h0,        1));
        vecs.push_back(mk(0, HSIZE_WORD, 32'h400, 32'h0,        32'h0,        1));
        vecs.push_back(mk(1, HSIZE_WORD, 32'h2,   32'hFFFFFFFF, 32'h0,        1));
        vecs.push_back(mk(1, HSIZE_WORD, 32'h400, 32'hFFFFFFFF, 32'h0,        1));
        vecs.push_back(mk(0, HSIZE_WORD, 32'h0,   32'h0,        32'hCAFEF00D, 0));
        vecs.push_back(mk(0, HSIZE_WORD, 32'h3FC, 32'h0,        32'h0F0F0F0F, 0));
        vecs.push_back(mk(0, HSIZE_HALF, 32'h2,   32'h0,        32'hCAFEF00D, 0));

        exp_txn = 0; exp_err = 0;
        foreach (vecs[i]) begin
            xfer(1'b0, vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wd, rd, rsp, lows, low_rsp);
            if (vecs[i].exp_err) exp_err++; else exp_txn++;
            chk($sformatf("v%0d hrdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d final hresp", i), 32'(rsp), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d low cycles", i), 32'(lows), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d low-cycle hresp", i), 32'(low_rsp), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d txn_count", i), 32'(txn0), 32'(exp_txn));
            chk($sformatf("v%0d err_count", i), 32'(err0), 32'(exp_err));
        end

        // Non-transfers: IDLE, BUSY, and NONSEQ without select.
        HSEL0 = 1'b1; HADDR = 32'h10; HWRITE = 1'b0; HSIZE = HSIZE_WORD; HTRANS = TRANS_IDLE;
        @(negedge HCLK);
        chk("idle hready", 32'(rdy0), 32'd1);
        HTRANS = TRANS_BUSY;
        @(negedge HCLK);
        chk("idle-after hrdata", rdata0, 32'd0);
        HSEL0 = 1'b0; HTRANS = TRANS_NONSEQ;
        @(negedge HCLK);
        chk("busy hrdata", rdata0, 32'd0);
        chk("busy hready", 32'(rdy0), 32'd1);
        @(negedge HCLK);
        chk("unselected hrdata", rdata0, 32'd0);
        HTRANS = TRANS_IDLE;
        @(negedge HCLK);
        chk("no-xfer txn_count", 32'(txn0), 32'(exp_txn));
        chk("no-xfer err_count", 32'(err0), 32'(exp_err));

        // Pipelined write, byte write, read of the same word.
        HSEL0 = 1'b1; HADDR = 32'h20; HTRANS = TRANS_NONSEQ; HWRITE = 1'b1; HSIZE = HSIZE_WORD;
        @(negedge HCLK);
        chk("raw w0 hready", 32'(rdy0), 32'd1);
        HWDATA = 32'h13572468; HADDR = 32'h21; HTRANS = TRANS_SEQ; HSIZE = HSIZE_BYTE;
        @(negedge HCLK);
        chk("raw w1 hready", 32'(rdy0), 32'd1);
        chk("raw w1 hrdata", rdata0, 32'd0);
        HWDATA = 32'h0000EE00; HADDR = 32'h20; HTRANS = TRANS_NONSEQ; HWRITE = 1'b0; HSIZE = HSIZE_WORD;
        @(negedge HCLK);
        chk("raw read hready", 32'(rdy0), 32'd1);
        chk("raw read hrdata", rdata0, 32'h1357EE68);
        HSEL0 = 1'b0; HTRANS = TRANS_IDLE;
        @(negedge HCLK);
        chk("raw txn_count", 32'(txn0), 32'(exp_txn + 3));

        // Random traffic on the wait-state instance against a word model.
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            xfer(1'b1, 1'b1, HSIZE_WORD, 32'(i * 4), model[i], rd, rsp, lows, low_rsp);
        end
        low_total = 0; t4_reads = 0;
        for (int n = 0; n < 1000; n++) begin
            logic        wr;
            logic [2:0]  sz;
            int          idx, ofs, nbytes;
            logic [31:0] wd;
            wr  = 1'($urandom_range(0, 1));
            sz  = 3'($urandom_range(0, 2));
            idx = $urandom_range(0, 15);
            nbytes = 1 << sz;
            ofs = (sz == HSIZE_BYTE) ? $urandom_range(0, 3) : (sz == HSIZE_HALF) ? 2 * $urandom_range(0, 1) : 0;
            wd  = $urandom;
            xfer(1'b1, wr, sz, 32'(idx * 4 + ofs), wd, rd, rsp, lows, low_rsp);
            low_total += lows;
            n_vec++;
            if (lows > 3) begin
                n_bad++;
                $display("FAIL t4 wait run #%0d: got %0d low cycles, limit 3", n, lows);
            end
            n_vec++;
            if (rsp !== 1'b0 || low_rsp !== 1'b0) begin
                n_bad++;
                $display("FAIL t4 hresp #%0d: got final %0b low %0b, expected 0", n, rsp, low_rsp);
            end
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (b >= ofs && b < ofs + nbytes) model[idx][8*b +: 8] = wd[8*b +: 8];
            end else begin
                t4_reads++;
                n_vec++;
                if (rd !== model[idx]) begin
                    n_bad++;
                    $display("FAIL t4 read #%0d word %0d: got 0x%08h, expected 0x%08h", n, idx, rd, model[idx]);
                end
            end
        end
        n_vec++;
        if (low_total == 0 || t4_reads == 0) begin
            n_bad++;
            $display("FAIL t4 activity: got %0d wait cycles %0d reads, expected both nonzero", low_total, t4_reads);
        end

        // Reset during the wait of a write must drop the write.
        got_wait = 1'b0;
        for (int t = 0; t < 30 && !got_wait; t++) begin
            xfer(1'b1, 1'b1, HSIZE_WORD, 32'h20, 32'h55, rd, rsp, lows, low_rsp);
            HSEL1 = 1'b1; HADDR = 32'h20; HTRANS = TRANS_NONSEQ; HWRITE = 1'b1; HSIZE = HSIZE_WORD;
            @(negedge HCLK);
            HSEL1 = 1'b0; HTRANS = TRANS_IDLE; HWDATA = 32'h99;
            if (rdy1 == 1'b0) begin
                got_wait = 1'b1;
                #2 HRESETn = 1'b0;
                #1;
                chk("abort hready", 32'(rdy1), 32'd1);
                chk("abort hresp", 32'(resp1), 32'd0);
                chk("abort hrdata", rdata1, 32'd0);
                chk("abort counts", {txn1, err1}, 32'd0);
                chk("abort counts inst0", {txn0, err0}, 32'd0);
                @(negedge HCLK);
                HRESETn = 1'b1;
                @(negedge HCLK);
            end else begin
                @(negedge HCLK);
            end
        end
        chk("abort saw wait state", 32'(got_wait), 32'd1);
        xfer(1'b1, 1'b0, HSIZE_WORD, 32'h20, 32'h0, rd, rsp, lows, low_rsp);
        chk("abort write dropped", rd, 32'h55);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
